ifu: RTL
========

IFU -- requirements
Module: ifu

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h80000000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter BUF_DEPTH, default 2, meaning instruction buffer entries; legal values are 2 and 4 only.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous and active-low (0 = reset).
REQ-005 The block SHALL have port mem_req_valid  out  1  fetch request valid.
REQ-006 The block SHALL have port mem_req_ready  in  1  memory accepts request.
REQ-007 The block SHALL have port mem_req_addr  out  32  fetch address, bits [1:0] always 0.
REQ-008 The block SHALL have port mem_rsp_valid  in  1  fetch response valid, one cycle per response.
REQ-009 The block SHALL have port mem_rsp_data  in  32  fetched instruction word.
REQ-010 The block SHALL have port mem_rsp_err  in  1  access fault on this response.
REQ-011 The block SHALL have port inst_valid  out  1  buffer head valid to decode.
REQ-012 The block SHALL have port inst_ready  in  1  decode consumes head.
REQ-013 The block SHALL have port inst  out  32  head instruction word.
REQ-014 The block SHALL have port inst_pc  out  32  head instruction address.
REQ-015 The block SHALL have port inst_err  out  1  head carries access fault.
REQ-016 The block SHALL have port redirect_valid  in  1  execute stage supplies a new PC.
REQ-017 The block SHALL have port redirect_pc  in  32  new PC; bits [1:0] are ignored and treated as 0.

Function
REQ-018 Handshakes SHALL complete on a rising edge where valid and ready are both 1; the memory port is non-sticky, so mem_req_valid/mem_req_addr may change in any cycle without a handshake.
REQ-019 At most one memory request SHALL be outstanding; its response arrives no earlier than the cycle after acceptance.
REQ-020 The FSM SHALL have states REQ, WAIT and DRAIN; reset state is REQ.
REQ-021 In REQ: mem_req_valid = 1 iff buffer occupancy < BUF_DEPTH and redirect_valid = 0; mem_req_addr = fetch_pc.
REQ-022 REQ -> WAIT on handshake; fetch_pc increments by 4 with 32-bit wrap (32'hFFFFFFFC -> 0).
REQ-023 WAIT -> REQ on mem_rsp_valid; {fetch address, mem_rsp_data, mem_rsp_err} is enqueued at the tail in the same edge.
REQ-024 A redirect SHALL flush the buffer (occupancy -> 0) and load fetch_pc with {redirect_pc[31:2], 2'b00} at the same edge.
REQ-025 On redirect in REQ, the state SHALL stay REQ.
REQ-026 On redirect in WAIT without mem_rsp_valid, the state SHALL go to DRAIN.
REQ-027 On redirect in WAIT with mem_rsp_valid in the same cycle, the response SHALL be discarded and the state SHALL go to REQ.
REQ-028 DRAIN SHALL discard the next mem_rsp_valid, enqueue nothing, and then go to REQ; a further redirect in DRAIN only updates fetch_pc.
REQ-029 inst_valid SHALL be (occupancy != 0) and not redirect_valid; inst, inst_pc and inst_err SHALL come from the head entry.
REQ-030 An inst handshake SHALL pop the head; a pop and an enqueue in the same cycle SHALL keep occupancy unchanged.
REQ-031 A fault SHALL not stop fetch; the faulting entry SHALL carry inst_err = 1 with whatever data was returned.
REQ-032 Head ordering SHALL be strict program order between redirects; the buffer is a circular FIFO with head and tail pointers wrapping modulo BUF_DEPTH.
REQ-033 The minimum latency SHALL be: request accepted in cycle N, response in cycle N+1, inst_valid = 1 in cycle N+2.

Reset
REQ-034 While rst = 0, all state SHALL be cleared asynchronously: state = REQ, fetch_pc = RESET_PC, occupancy = 0, and pointers = 0.
REQ-035 While rst = 0, the outputs SHALL be: mem_req_valid = 0, inst_valid = 0, inst = 0, inst_pc = 0, inst_err = 0.
REQ-036 Reset asserted mid-transaction SHALL abandon any outstanding request; the testbench SHALL hold mem_rsp_valid = 0 during reset and for the first cycle after release.
REQ-037 In the first cycle after rst rises: mem_req_valid = 1 and mem_req_addr = RESET_PC.

Verification
REQ-038 Scenario: reset release with mem_req_ready = 1, 1-cycle memory, inst_ready = 1 -> addresses 80000000, 80000004, 80000008 issued; inst_pc stream matches in order, first inst_valid two cycles after the first accept.
REQ-039 Scenario: inst_ready = 0 with BUF_DEPTH = 2 -> two entries buffered, then mem_req_valid = 0; one pop -> exactly one new request.
REQ-040 Scenario: redirect_pc = 32'h80000103 while in WAIT -> stale response dropped, next request address 80000100, no stale inst delivered.
REQ-041 Scenario: redirect in the same cycle as mem_rsp_valid and an inst pop -> occupancy 0, next request at the redirect target.
REQ-042 Scenario: mem_rsp_err = 1 on 80000004 -> entry delivered with inst_err = 1, fetch continues at 80000008.
REQ-043 Scenario: rst pulsed low while in WAIT -> outputs reset immediately; first request after release at 80000000.

Source files
------------

// File: rtl/ifu_if.sv
// Bus bundle for the instruction fetch unit: memory request/response channel,
// decode-side instruction handshake and execute-stage redirect.
interface ifu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output inst_valid, inst, inst_pc, inst_err,
    input  inst_ready,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  inst_valid, inst, inst_pc, inst_err,
    output inst_ready,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: single-outstanding memory fetcher feeding a small
// circular instruction buffer, with redirect flush and stale-response drain.
module ifu #(
  parameter logic [31:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst,
  ifu_if.master bus
);

  localparam int unsigned PW = $clog2(BUF_DEPTH);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DRAIN
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] occ;

  logic [31:0]   buf_data [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic          buf_err  [BUF_DEPTH];

  logic          req_ok;
  logic          req_hs;
  logic          enq;
  logic          head_ok;
  logic          pop;
  logic          has_head;
  logic          unused_lo;

  assign unused_lo = ^bus.redirect_pc[1:0];

  always_comb begin
    state_nxt = state;
    req_ok    = 1'b0;
    enq       = 1'b0;
    unique case (state)
      REQ: begin
        req_ok = (occ < CW'(BUF_DEPTH)) && !bus.redirect_valid;
        if (req_ok && bus.mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        // A redirect coinciding with the response consumes it; otherwise the
        // in-flight response must still be swallowed in DRAIN.
        if (bus.redirect_valid) begin
          state_nxt = bus.mem_rsp_valid ? REQ : DRAIN;
        end else if (bus.mem_rsp_valid) begin
          enq       = 1'b1;
          state_nxt = REQ;
        end
      end
      DRAIN: begin
        if (bus.mem_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  assign req_hs   = req_ok && bus.mem_req_ready;
  assign head_ok  = (occ != '0) && !bus.redirect_valid;
  assign pop      = head_ok && bus.inst_ready;
  assign has_head = rst && (occ != '0);

  assign bus.mem_req_valid = rst && req_ok;
  assign bus.mem_req_addr  = {fetch_pc[31:2], 2'b00};
  assign bus.inst_valid    = rst && head_ok;
  assign bus.inst          = has_head ? buf_data[head] : '0;
  assign bus.inst_pc       = has_head ? buf_pc[head]   : '0;
  assign bus.inst_err      = has_head ? buf_err[head]  : 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= REQ;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      req_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
    end else begin
      if (req_hs) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;
      end
      // Pointer width equals log2(BUF_DEPTH), so natural overflow is the wrap.
      if (enq) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
      unique case ({enq, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_data[tail] <= bus.mem_rsp_data;
      buf_pc[tail]   <= req_pc;
      buf_err[tail]  <= bus.mem_rsp_err;
    end
  end

endmodule
